// File: rtl/music_player.sv
// music_player: background-music PCM source for speaker_control.
// Picks a track from the game state, steps a note sheet at the beat rate, emits volume-scaled square waves.
//   track  | meaning
//   TITLE  | state 0, title theme, right channel mirrors left
//   GAME   | state 1..7, in-game theme, right channel one octave lower
//   SILENT | state 8..15, both channels held at zero
module music_player #(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned BEAT_HZ   = 8,
  parameter int unsigned SHEET_LEN = 64,
  parameter int unsigned VOL_MAX   = 5,
  parameter int unsigned VOL_INIT  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         state,
  input  logic               vol_up,
  input  logic               vol_down,
  input  logic               mute,
  output logic signed [15:0] audio_in_left,
  output logic signed [15:0] audio_in_right,
  output logic [2:0]         volume,
  output logic [5:0]         beat_idx
);

  localparam logic [1:0] TRK_TITLE  = 2'd0;
  localparam logic [1:0] TRK_GAME   = 2'd1;
  localparam logic [1:0] TRK_SILENT = 2'd2;

  localparam logic [31:0] BEAT_LAST = 32'(CLK_HZ / BEAT_HZ - 1);
  localparam logic [5:0]  IDX_MASK  = 6'(SHEET_LEN - 1);

  // Half-periods from note frequencies in milli-Hz: CLK_HZ*1000 / (2*f).
  localparam logic [63:0] HP_NUM = 64'(CLK_HZ) * 64'd500;
  localparam logic [31:0] HP_TAB [12] = '{
    32'(HP_NUM / 64'd261626), 32'(HP_NUM / 64'd277183), 32'(HP_NUM / 64'd293665),
    32'(HP_NUM / 64'd311127), 32'(HP_NUM / 64'd329628), 32'(HP_NUM / 64'd349228),
    32'(HP_NUM / 64'd369994), 32'(HP_NUM / 64'd391995), 32'(HP_NUM / 64'd415305),
    32'(HP_NUM / 64'd440000), 32'(HP_NUM / 64'd466164), 32'(HP_NUM / 64'd493883)
  };

  localparam logic [4:0] SHEET_TITLE [64] = '{
    5'd10, 5'd0,  5'd10, 5'd13, 5'd15, 5'd13, 5'd10, 5'd8,
    5'd10, 5'd0,  5'd8,  5'd6,  5'd5,  5'd6,  5'd8,  5'd0,
    5'd10, 5'd10, 5'd13, 5'd13, 5'd15, 5'd15, 5'd17, 5'd0,
    5'd15, 5'd13, 5'd12, 5'd13, 5'd10, 5'd0,  5'd8,  5'd0,
    5'd6,  5'd6,  5'd8,  5'd10, 5'd8,  5'd6,  5'd5,  5'd0,
    5'd3,  5'd5,  5'd6,  5'd8,  5'd10, 5'd8,  5'd6,  5'd0,
    5'd10, 5'd0,  5'd13, 5'd12, 5'd10, 5'd8,  5'd6,  5'd5,
    5'd3,  5'd5,  5'd6,  5'd5,  5'd3,  5'd1,  5'd0,  5'd0
  };

  localparam logic [4:0] SHEET_GAME [64] = '{
    5'd10, 5'd10, 5'd13, 5'd10, 5'd15, 5'd13, 5'd10, 5'd8,
    5'd6,  5'd6,  5'd10, 5'd6,  5'd13, 5'd10, 5'd6,  5'd5,
    5'd8,  5'd8,  5'd12, 5'd8,  5'd15, 5'd12, 5'd8,  5'd6,
    5'd3,  5'd3,  5'd8,  5'd3,  5'd12, 5'd8,  5'd3,  5'd1,
    5'd10, 5'd0,  5'd10, 5'd0,  5'd13, 5'd0,  5'd15, 5'd0,
    5'd6,  5'd0,  5'd6,  5'd0,  5'd10, 5'd0,  5'd13, 5'd0,
    5'd8,  5'd8,  5'd8,  5'd8,  5'd12, 5'd12, 5'd12, 5'd12,
    5'd3,  5'd5,  5'd6,  5'd8,  5'd10, 5'd12, 5'd13, 5'd0
  };

  function automatic logic [4:0] note_rom(input logic [1:0] trk, input logic [5:0] idx);
    logic [4:0] c;
    case (trk)
      TRK_TITLE: c = SHEET_TITLE[idx];
      TRK_GAME:  c = SHEET_GAME[idx];
      default:   c = 5'd0;
    endcase
    if (c > 5'd24) c = 5'd0;
    return c;
  endfunction

  function automatic logic [31:0] half_period(input logic [4:0] code);
    logic [31:0] hp;
    logic [4:0]  off;
    hp  = '0;
    off = '0;
    if (code >= 5'd1 && code <= 5'd12) begin
      off = code - 5'd1;
      hp  = HP_TAB[off[3:0]];
    end else if (code >= 5'd13 && code <= 5'd24) begin
      off = code - 5'd13;
      hp  = HP_TAB[off[3:0]] >> 1;
    end
    return hp;
  endfunction

  logic [1:0]  track_q, track_d, track_prev_q;
  logic [31:0] beat_cnt_q, beat_cnt_d;
  logic [5:0]  beat_idx_q, beat_idx_d;
  logic [31:0] tone_l_q, tone_l_d, tone_r_q, tone_r_d;
  logic        phase_l_q, phase_l_d, phase_r_q, phase_r_d;
  logic [2:0]  vol_q, vol_d;
  logic [15:0] audio_l_q, audio_l_d, audio_r_q, audio_r_d;

  logic        track_chg, beat_tick, note_restart, silent, phase_sel_r;
  logic [5:0]  idx_next;
  logic [4:0]  code_cur, code_next;
  logic [31:0] hp_l, hp_r;
  logic [15:0] amp;

  always_comb begin
    if (state == 4'd0)  track_d = TRK_TITLE;
    else if (state[3])  track_d = TRK_SILENT;
    else                track_d = TRK_GAME;
  end

  assign track_chg    = (track_q != track_prev_q);
  assign beat_tick    = (beat_cnt_q >= BEAT_LAST);
  assign idx_next     = (beat_idx_q + 6'd1) & IDX_MASK;
  assign code_cur     = note_rom(track_q, beat_idx_q);
  assign code_next    = note_rom(track_q, idx_next);
  assign note_restart = track_chg | (beat_tick & (code_next != code_cur));
  assign hp_l         = half_period(code_cur);
  // Right channel runs at twice the half-period: one octave under the melody.
  assign hp_r         = hp_l << 1;

  always_comb begin
    beat_cnt_d = beat_cnt_q + 32'd1;
    beat_idx_d = beat_idx_q;
    if (track_chg) begin
      beat_cnt_d = '0;
      beat_idx_d = '0;
    end else if (beat_tick) begin
      beat_cnt_d = '0;
      beat_idx_d = idx_next;
    end
  end

  always_comb begin
    tone_l_d  = tone_l_q;
    tone_r_d  = tone_r_q;
    phase_l_d = phase_l_q;
    phase_r_d = phase_r_q;
    if (note_restart) begin
      tone_l_d  = '0;
      tone_r_d  = '0;
      phase_l_d = 1'b1;
      phase_r_d = 1'b1;
    end else if (hp_l != 32'd0) begin
      if (tone_l_q >= hp_l - 32'd1) begin
        tone_l_d  = '0;
        phase_l_d = ~phase_l_q;
      end else begin
        tone_l_d = tone_l_q + 32'd1;
      end
      if (tone_r_q >= hp_r - 32'd1) begin
        tone_r_d  = '0;
        phase_r_d = ~phase_r_q;
      end else begin
        tone_r_d = tone_r_q + 32'd1;
      end
    end
  end

  always_comb begin
    vol_d = vol_q;
    if (vol_up && !vol_down && (vol_q < 3'(VOL_MAX)))
      vol_d = vol_q + 3'd1;
    else if (vol_down && !vol_up && (vol_q != 3'd0))
      vol_d = vol_q - 3'd1;
  end

  assign amp         = {1'b0, vol_q, 12'h000};
  assign silent      = mute | (vol_q == 3'd0) | (code_cur == 5'd0) | (track_q == TRK_SILENT);
  assign phase_sel_r = (track_q == TRK_GAME) ? phase_r_q : phase_l_q;

  always_comb begin
    audio_l_d = '0;
    audio_r_d = '0;
    if (!silent) begin
      audio_l_d = phase_l_q   ? amp : (16'h0000 - amp);
      audio_r_d = phase_sel_r ? amp : (16'h0000 - amp);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      track_q      <= TRK_TITLE;
      track_prev_q <= TRK_TITLE;
      beat_cnt_q   <= '0;
      beat_idx_q   <= '0;
      tone_l_q     <= '0;
      tone_r_q     <= '0;
      phase_l_q    <= 1'b1;
      phase_r_q    <= 1'b1;
      vol_q        <= 3'(VOL_INIT);
      audio_l_q    <= '0;
      audio_r_q    <= '0;
    end else begin
      track_q      <= track_d;
      track_prev_q <= track_q;
      beat_cnt_q   <= beat_cnt_d;
      beat_idx_q   <= beat_idx_d;
      tone_l_q     <= tone_l_d;
      tone_r_q     <= tone_r_d;
      phase_l_q    <= phase_l_d;
      phase_r_q    <= phase_r_d;
      vol_q        <= vol_d;
      audio_l_q    <= audio_l_d;
      audio_r_q    <= audio_r_d;
    end
  end

  assign audio_in_left  = audio_l_q;
  assign audio_in_right = audio_r_q;
  assign volume         = vol_q;
  assign beat_idx       = beat_idx_q;

endmodule

// File: tb/tb_music_player.sv
// Directed bench for music_player, scaled to CLK_HZ=50_000 / BEAT_HZ=200 so a note spans several half-periods:
// beat = 250 cycles, A4 half-period = floor(50000/880) = 56, right channel in GAME = 112.
module tb_music_player;

  localparam int HP_L = 56;
  localparam int HP_R = 112;
  localparam int BEAT = 250;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [3:0]        state = 4'd0;
  logic              vol_up = 1'b0;
  logic              vol_down = 1'b0;
  logic              mute = 1'b0;
  logic signed [15:0] audio_l, audio_r;
  logic [2:0]        volume;
  logic [5:0]        beat_idx;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;

  music_player #(
    .CLK_HZ(50_000), .BEAT_HZ(200), .SHEET_LEN(64), .VOL_MAX(5), .VOL_INIT(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .state(state), .vol_up(vol_up), .vol_down(vol_down),
    .mute(mute), .audio_in_left(audio_l), .audio_in_right(audio_r),
    .volume(volume), .beat_idx(beat_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int target);
    tick(target - cyc);
  endtask

  // Square-wave reference: sample after edge n reflects the phase after edge n-1,
  // with the tone counter restarted (phase=1) at edge s.
  function automatic logic [15:0] tone(input int n, input int s, input int hp, input int vol);
    logic [15:0] a;
    a = 16'(vol) << 12;
    if ((((n - 1 - s) / hp) % 2) == 0) return a;
    return 16'h0000 - a;
  endfunction

  task automatic pulse(input logic up, input logic down);
    vol_up = up;
    vol_down = down;
    tick(1);
    vol_up = 1'b0;
    vol_down = 1'b0;
    tick(1);
  endtask

  initial begin
    int rel, s, g, h, bad;

    tick(3);
    check("rst_volume", 16'(volume), 16'd3);
    check("rst_beat_idx", 16'(beat_idx), 16'd0);
    check("rst_left", audio_l, 16'h0000);
    check("rst_right", audio_r, 16'h0000);

    rst_n = 1'b1;
    rel = cyc;
    tick(1);
    check("first_left", audio_l, 16'h3000);
    check("first_right", audio_r, 16'h3000);
    run_to(rel + 56);
    check("pre_toggle_left", audio_l, 16'h3000);
    run_to(rel + 57);
    check("toggle_left", audio_l, 16'hD000);
    check("toggle_right_eq_left", audio_r, 16'hD000);
    run_to(rel + 113);
    check("retoggle_left", audio_l, 16'h3000);
    run_to(rel + 249);
    check("beat0_idx", 16'(beat_idx), 16'd0);
    check("beat0_left_model", audio_l, tone(cyc, rel, HP_L, 3));
    run_to(rel + 250);
    check("beat1_idx", 16'(beat_idx), 16'd1);
    run_to(rel + 251);
    check("rest_left", audio_l, 16'h0000);
    check("rest_right", audio_r, 16'h0000);

    run_to(rel + 64 * BEAT - 1);
    check("idx_63", 16'(beat_idx), 16'd63);
    run_to(rel + 64 * BEAT);
    check("idx_wrap", 16'(beat_idx), 16'd0);
    s = cyc;
    run_to(s + 1);
    check("wrap_restart_left", audio_l, 16'h3000);
    run_to(s + 57);
    check("wrap_toggle_left", audio_l, tone(cyc, s, HP_L, 3));

    for (int i = 0; i < 4; i++) pulse(1'b1, 1'b0);
    check("vol_sat_max", 16'(volume), 16'd5);
    tick(1);
    check("amp_max_left", audio_l, tone(cyc, s, HP_L, 5));
    check("amp_max_right", audio_r, tone(cyc, s, HP_L, 5));
    for (int i = 0; i < 7; i++) pulse(1'b0, 1'b1);
    check("vol_sat_zero", 16'(volume), 16'd0);
    tick(1);
    check("vol_zero_left", audio_l, 16'h0000);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    vol_up = 1'b1;
    vol_down = 1'b1;
    tick(1);
    vol_up = 1'b0;
    vol_down = 1'b0;
    check("vol_both_hold", 16'(volume), 16'd2);
    tick(1);
    check("vol2_left", audio_l, tone(cyc, s, HP_L, 2));
    pulse(1'b1, 1'b0);
    check("vol_back_3", 16'(volume), 16'd3);

    mute = 1'b1;
    tick(1);
    check("mute_left", audio_l, 16'h0000);
    check("mute_right", audio_r, 16'h0000);
    tick(49);
    check("mute_hold_left", audio_l, 16'h0000);
    mute = 1'b0;
    tick(1);
    check("unmute_left", audio_l, tone(cyc, s, HP_L, 3));
    check("unmute_right", audio_r, tone(cyc, s, HP_L, 3));
    run_to(s + 170);
    check("unmute_later_left", audio_l, tone(cyc, s, HP_L, 3));

    run_to(s + 400);
    check("midbeat_idx", 16'(beat_idx), 16'd1);
    state = 4'd3;
    tick(2);
    check("game_idx_reset", 16'(beat_idx), 16'd0);
    g = cyc;
    run_to(g + 1);
    check("game_left_start", audio_l, 16'h3000);
    check("game_right_start", audio_r, 16'h3000);
    run_to(g + 57);
    check("game_left_toggle", audio_l, tone(cyc, g, HP_L, 3));
    check("game_right_hold", audio_r, tone(cyc, g, HP_R, 3));
    run_to(g + 113);
    check("game_left_113", audio_l, tone(cyc, g, HP_L, 3));
    check("game_right_toggle", audio_r, tone(cyc, g, HP_R, 3));

    state = 4'd9;
    tick(2);
    check("silent_left", audio_l, 16'h0000);
    check("silent_right", audio_r, 16'h0000);
    check("silent_idx", 16'(beat_idx), 16'd0);
    h = cyc;
    bad = 0;
    for (int i = 1; i <= 64 * BEAT; i++) begin
      tick(1);
      if (audio_l !== 16'h0000 || audio_r !== 16'h0000) bad++;
      if (i == BEAT) check("silent_idx_step", 16'(beat_idx), 16'd1);
    end
    check("silent_sweep_nonzero", 16'(bad), 16'd0);
    check("silent_idx_wrap", 16'(beat_idx), 16'd0);

    pulse(1'b1, 1'b0);
    check("vol_4", 16'(volume), 16'd4);
    state = 4'd0;
    tick(2);
    g = cyc;
    tick(10);
    check("pre_async_left", audio_l, tone(cyc, g, HP_L, 4));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_left", audio_l, 16'h0000);
    check("async_right", audio_r, 16'h0000);
    check("async_volume", 16'(volume), 16'd3);
    check("async_idx", 16'(beat_idx), 16'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check("post_async_left", audio_l, 16'h3000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
